// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI target block.
// No logic; imported by the synchronizer and the top level.
// No flow control of its own.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_slave_state_e;

  localparam int SPI_DEFAULT_DATA_WIDTH = 8;
  localparam int SPI_MIN_SYNC_STAGES    = 2;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between a master and this target.
// Pure wiring, zero latency.
// No backpressure; timing is set by the master's spi_clk.
interface spi_slave_if;

  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe
  );

endinterface

// File: rtl/spi_sync.sv
// N-stage single-bit synchronizer with a configurable reset value.
// Latency: STAGES clk cycles.
// No backpressure; samples every cycle.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = SPI_MIN_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) sr <= {STAGES{RST_VAL}};
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled pins, all CPOL/CPHA modes, MSB first, one-word tx buffer.
// Latency: rx_valid a few clk cycles after the final sampling edge (sync depth + detect).
// No backpressure: host must refill tx before a word starts or the word goes out as zeros.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_MIN_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  tx_underrun,
  spi_slave_if.slave            spi
);

  // Fewer than two stages is not a synchronizer; clamp silently.
  localparam int STAGES = (SYNC_STAGES < SPI_MIN_SYNC_STAGES) ? SPI_MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;
  logic [STAGES-1:0] flush_sr;
  logic armed;

  spi_slave_state_e state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic tx_full, frame_start, und_pend;

  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic do_sample, do_shift, word_done, abort, und_now;

  spi_sync #(.STAGES(STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .d(spi.spi_clk), .q(sclk_s));
  spi_sync #(.STAGES(STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi.spi_cs_n), .q(cs_n_s));
  spi_sync #(.STAGES(STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi.spi_mosi), .q(mosi_s));

  // Delayed copies for edge detection; arm only after cs is seen high with a flushed sync chain,
  // so a cs held low across reset cannot masquerade as a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d   <= 1'b0;
      cs_n_d   <= 1'b1;
      flush_sr <= '0;
      armed    <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      cs_n_d   <= cs_n_s;
      flush_sr <= {flush_sr[STAGES-2:0], 1'b1};
      if (flush_sr[STAGES-1] && cs_n_s) armed <= 1'b1;
    end
  end

  assign sclk_edge   = sclk_s ^ sclk_d;
  assign lead_edge   = sclk_edge && (sclk_d == cpol);
  assign trail_edge  = sclk_edge && (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;
  assign cs_fall     = armed && cs_n_d && !cs_n_s;
  assign cs_rise     = !cs_n_d && cs_n_s;
  assign rx_next     = {rx_sh, mosi_s};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_d   = state_q;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    und_now   = 1'b0;
    case (state_q)
      IDLE:  if (cs_fall) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        do_sample = sample_edge;
        // Count 0 means no bit of this word sampled yet: the MSB is already on miso,
        // and a trailing edge here still belongs to the previous word.
        do_shift  = shift_edge && (bit_cnt != '0);
        und_now   = und_pend && lead_edge && (bit_cnt == '0);
        if (sample_edge && bit_cnt == LAST_BIT) begin
          word_done = 1'b1;
          state_d   = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cs_rise) begin
      state_d = IDLE;
      if (state_q == SHIFT && !word_done && bit_cnt != '0 && bit_cnt < FULL_CNT) abort = 1'b1;
    end
  end

  // One-word transmit buffer; a load in the LOAD cycle refills after the old word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (tx_load && !tx_full) begin
      tx_buf  <= tx_data;
      tx_full <= 1'b1;
    end else if (state_q == LOAD) begin
      tx_full <= 1'b0;
    end
  end

  // Shift registers, bit counter and received word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else if (state_q == LOAD) begin
      tx_sh   <= tx_full ? tx_buf : '0;
      bit_cnt <= '0;
    end else begin
      if (do_sample) begin
        rx_sh   <= rx_next[DATA_WIDTH-2:0];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (do_shift)  tx_sh   <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      if (word_done) rx_data <= rx_next;
    end
  end

  // Status pulses. An empty buffer at frame start flags at once; between words it waits for
  // the next word's first clock edge, since cs may instead rise and end the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      frame_start <= 1'b0;
      und_pend    <= 1'b0;
    end else begin
      rx_valid    <= word_done;
      frame_err   <= abort;
      tx_underrun <= 1'b0;
      if (state_q == IDLE && cs_fall) frame_start <= 1'b1;
      if (state_q == LOAD) begin
        frame_start <= 1'b0;
        if (!tx_full) begin
          if (frame_start) tx_underrun <= 1'b1;
          else             und_pend    <= 1'b1;
        end
      end
      if (und_now) begin
        tx_underrun <= 1'b1;
        und_pend    <= 1'b0;
      end
      if (state_d == IDLE) und_pend <= 1'b0;
    end
  end

  assign tx_ready        = !tx_full;
  assign busy            = !cs_n_s;
  assign spi.spi_miso    = tx_sh[DATA_WIDTH-1];
  assign spi.spi_miso_oe = !cs_n_s;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int HP = 4;  // spi_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, tx_load;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, frame_err, tx_underrun;
  logic [7:0] rx_data;

  int checks = 0;
  int failures = 0;
  int rxv_cnt = 0, ferr_cnt = 0, und_cnt = 0;

  spi_slave_if sif ();

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .tx_underrun(tx_underrun),
    .spi(sif)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)    rxv_cnt  <= rxv_cnt + 1;
      if (frame_err)   ferr_cnt <= ferr_cnt + 1;
      if (tx_underrun) und_cnt  <= und_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sif.spi_clk = pol;
    tick(6);
  endtask

  task automatic cs_low();
    sif.spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    sif.spi_cs_n = 1'b1;
    tick(8);
  endtask

  // Master side: clock out the top nbits of tx MSB first, capture miso.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        sif.spi_mosi = tx[i];
        tick(HP);
        rx[i] = sif.spi_miso;
        sif.spi_clk = ~cpol;
        tick(HP);
        sif.spi_clk = cpol;
      end else begin
        tick(HP);
        sif.spi_clk = ~cpol;
        sif.spi_mosi = tx[i];
        tick(HP);
        rx[i] = sif.spi_miso;
        sif.spi_clk = cpol;
      end
    end
    tick(HP);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b1;
    tick(4);
    got = {tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun, sif.spi_miso, sif.spi_miso_oe};
    checks++;
    if (got !== 16'b1_00000000_0_0_0_0_0_0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b", got, 16'b1_00000000_0_0_0_0_0_0);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_mode0();
    logic [7:0] mrx;
    int v0, f0, u0;
    set_mode(1'b0, 1'b0);
    host_load(8'h3C);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_load_ready: got %b expected 0", tx_ready); end
    v0 = rxv_cnt; f0 = ferr_cnt; u0 = und_cnt;
    cs_low();
    checks++;
    if (busy !== 1'b1 || sif.spi_miso_oe !== 1'b1) begin
      failures++; $display("FAIL m0_busy: got busy=%b oe=%b expected 1 1", busy, sif.spi_miso_oe);
    end
    xfer(8'hA5, 8, mrx);
    cs_high();
    checks++;
    if (rx_data !== 8'hA5) begin failures++; $display("FAIL m0_rx: got %h expected a5", rx_data); end
    checks++;
    if (mrx !== 8'h3C) begin failures++; $display("FAIL m0_miso: got %h expected 3c", mrx); end
    checks++;
    if (rxv_cnt - v0 !== 1) begin failures++; $display("FAIL m0_rxvalid: got %0d expected 1", rxv_cnt - v0); end
    checks++;
    if (ferr_cnt - f0 !== 0 || und_cnt - u0 !== 0) begin
      failures++; $display("FAIL m0_errs: got ferr=%0d und=%0d expected 0 0", ferr_cnt - f0, und_cnt - u0);
    end
    checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++; $display("FAIL m0_idle: got busy=%b tx_ready=%b expected 0 1", busy, tx_ready);
    end
  endtask

  task automatic test_modes();
    logic [7:0] mosi_v [3] = '{8'h5A, 8'hC3, 8'h81};
    logic [7:0] pre_v  [3] = '{8'h0F, 8'hF0, 8'h7E};
    logic [7:0] mrx;
    int v0;
    for (int m = 1; m <= 3; m++) begin
      set_mode(m[1], m[0]);
      host_load(pre_v[m-1]);
      v0 = rxv_cnt;
      cs_low();
      xfer(mosi_v[m-1], 8, mrx);
      cs_high();
      checks++;
      if (rx_data !== mosi_v[m-1]) begin
        failures++; $display("FAIL mode%0d_rx: got %h expected %h", m, rx_data, mosi_v[m-1]);
      end
      checks++;
      if (mrx !== pre_v[m-1]) begin
        failures++; $display("FAIL mode%0d_miso: got %h expected %h", m, mrx, pre_v[m-1]);
      end
      checks++;
      if (rxv_cnt - v0 !== 1) begin
        failures++; $display("FAIL mode%0d_rxvalid: got %0d expected 1", m, rxv_cnt - v0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1;
    int v0, u0;
    set_mode(1'b0, 1'b0);
    host_load(8'h11);
    v0 = rxv_cnt; u0 = und_cnt;
    cs_low();
    // The next word's LOAD follows the last sample immediately, so the refill goes in while
    // the first word is still shifting.
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_consumed: got %b expected 1", tx_ready); end
    host_load(8'h22);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_refill: got %b expected 0", tx_ready); end
    xfer(8'hAA, 8, r0);
    checks++;
    if (rx_data !== 8'hAA || rxv_cnt - v0 !== 1) begin
      failures++; $display("FAIL b2b_word0: got %h n=%0d expected aa n=1", rx_data, rxv_cnt - v0);
    end
    xfer(8'h55, 8, r1);
    cs_high();
    checks++;
    if (rx_data !== 8'h55 || rxv_cnt - v0 !== 2) begin
      failures++; $display("FAIL b2b_word1: got %h n=%0d expected 55 n=2", rx_data, rxv_cnt - v0);
    end
    checks++;
    if (r0 !== 8'h11 || r1 !== 8'h22) begin
      failures++; $display("FAIL b2b_miso: got %h %h expected 11 22", r0, r1);
    end
    checks++;
    if (und_cnt - u0 !== 0) begin failures++; $display("FAIL b2b_underrun: got %0d expected 0", und_cnt - u0); end
  endtask

  task automatic test_underrun();
    logic [7:0] mrx;
    int u0;
    set_mode(1'b0, 1'b0);
    u0 = und_cnt;
    cs_low();
    checks++;
    if (und_cnt - u0 !== 1) begin failures++; $display("FAIL und_pulse: got %0d expected 1", und_cnt - u0); end
    xfer(8'h96, 8, mrx);
    cs_high();
    checks++;
    if (mrx !== 8'h00) begin failures++; $display("FAIL und_miso: got %h expected 00", mrx); end
    checks++;
    if (rx_data !== 8'h96) begin failures++; $display("FAIL und_rx: got %h expected 96", rx_data); end
    checks++;
    if (und_cnt - u0 !== 1) begin failures++; $display("FAIL und_total: got %0d expected 1", und_cnt - u0); end
  endtask

  task automatic test_abort();
    logic [7:0] mrx;
    int v0, f0;
    set_mode(1'b0, 1'b0);
    host_load(8'h99);
    v0 = rxv_cnt; f0 = ferr_cnt;
    cs_low();
    xfer(8'hF0, 3, mrx);
    cs_high();
    checks++;
    if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL abort_ferr: got %0d expected 1", ferr_cnt - f0); end
    checks++;
    if (rxv_cnt - v0 !== 0) begin failures++; $display("FAIL abort_rxvalid: got %0d expected 0", rxv_cnt - v0); end
    checks++;
    if (rx_data !== 8'h96) begin failures++; $display("FAIL abort_rxhold: got %h expected 96", rx_data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mrx;
    logic [15:0] got;
    int v0, f0, u0;
    set_mode(1'b0, 1'b0);
    host_load(8'h4D);
    cs_low();
    xfer(8'hFF, 4, mrx);
    rst = 1'b1;
    tick(2);
    got = {tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun, sif.spi_miso, sif.spi_miso_oe};
    checks++;
    if (got !== 16'b1_00000000_0_0_0_0_0_0) begin
      failures++; $display("FAIL rstmid_outputs: got %b expected %b", got, 16'b1_00000000_0_0_0_0_0_0);
    end
    rst = 1'b0;
    // cs is still low: no frame may start until it goes high and falls again.
    u0 = und_cnt; f0 = ferr_cnt; v0 = rxv_cnt;
    xfer(8'hFF, 2, mrx);
    cs_high();
    checks++;
    if (und_cnt - u0 !== 0 || ferr_cnt - f0 !== 0 || rxv_cnt - v0 !== 0) begin
      failures++;
      $display("FAIL rstmid_nostart: got und=%0d ferr=%0d rxv=%0d expected 0 0 0",
               und_cnt - u0, ferr_cnt - f0, rxv_cnt - v0);
    end
    host_load(8'h6B);
    cs_low();
    xfer(8'hA5, 8, mrx);
    cs_high();
    checks++;
    if (rx_data !== 8'hA5 || rxv_cnt - v0 !== 1) begin
      failures++; $display("FAIL rstmid_rx: got %h n=%0d expected a5 n=1", rx_data, rxv_cnt - v0);
    end
    checks++;
    if (mrx !== 8'h6B) begin failures++; $display("FAIL rstmid_miso: got %h expected 6b", mrx); end
    checks++;
    if (und_cnt - u0 !== 0 || ferr_cnt - f0 !== 0) begin
      failures++; $display("FAIL rstmid_errs: got und=%0d ferr=%0d expected 0 0", und_cnt - u0, ferr_cnt - f0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    tx_load = 1'b0;
    tx_data = 8'h00;
    sif.spi_clk = 1'b0;
    sif.spi_cs_n = 1'b1;
    sif.spi_mosi = 1'b0;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
